jzjpcc_muldiv_sequencer: RTL and testbench
==========================================

# jzjpcc_muldiv_sequencer

Iterative RV32M multiply/divide controller for the execute stage. It accepts a MUL/DIV/REM operation already decoded into the execute stage and runs a shift-add multiplier or restoring divider over multiple cycles. While it runs, it stalls the pipeline. When the operation finishes, it presents a 32-bit result alongside the ALU result for the execute-to-memory latch.

## Interface
- `PC_MAX_B`, default 31. Kept for stage-parameter uniformity; it does not affect this block's logic.
- `clock` in 1. Pipeline clock.
- `reset` in 1. Asynchronous, active-high.
- `start_execute` in 1. A valid M-extension instruction is in the execute stage.
- `mulDivOp_execute` in 3. funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_execute` in 32. Dividend or multiplicand.
- `rs2_execute` in 32. Divisor or multiplier.
- `flush_execute` in 1. Aborts the in-flight operation.
- `stall_execute` out 1. Holds the fetch, decode and execute stages.
- `mulDivResult_execute` out 32. Final result; valid only while `resultValid_execute` is high.
- `resultValid_execute` out 1. One-cycle completion strobe.
- `busy` out 1. State is not IDLE.

## Operation
- States:
  - **IDLE**: waits for a start.
  - **RUN**: performs iterations.
  - **DONE**: presents the result.
- **IDLE to RUN**: taken when `start_execute` is high and `flush_execute` is low. On this edge the block latches:
  - the op,
  - |rs1| and |rs2|, where signedness comes from the op (MULHSU treats rs1 as signed and rs2 as unsigned),
  - the result sign,
  - iteration counter = 0.
- **RUN**: one radix-2 step per cycle; 32 steps in total.
  - Multiply: 64-bit product register. Add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: 64-bit remainder:quotient register. Shift left, trial subtract the divisor, set the quotient bit if the result is non-negative.
  - The counter is 5 bits. After step 31 it wraps to 0 and the state moves to DONE.
- **DONE**:
  - Applies sign correction by 2's-complement negation of the magnitude result.
  - Selects the output word: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - The remainder takes the sign of the dividend.
  - Drives `resultValid_execute` = 1 and moves unconditionally to IDLE.
- **Divide by zero** (unconditional): quotient = 0xFFFFFFFF, remainder = rs1. No exception is raised.
- **Signed overflow** (unconditional): DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- **Flush** in any state: next state is IDLE and no `resultValid_execute` is produced. Flush has priority over start.
- **Start during DONE** is ignored, because the same instruction is still in execute. A new start is sampled only in IDLE.
- **Reset**, asynchronous, including mid-operation:
  - state = IDLE, counter = 0, datapath registers = 0;
  - `stall_execute` = 0, `resultValid_execute` = 0, `mulDivResult_execute` = 0, `busy` = 0.

## Timing
- `stall_execute` is combinational: (IDLE && `start_execute` && !`flush_execute`) || RUN. It is low in DONE so the pipeline advances at the end of the DONE cycle.
- A start sampled in cycle N gives:
  - RUN in cycles N+1 to N+32,
  - DONE in cycle N+33, when `mulDivResult_execute` is valid and is latched by the execute-to-memory register at the end of that cycle.
- Total occupancy of execute is 34 cycles (N to N+33).
- `mulDivResult_execute` is combinational from the registered DONE-state datapath. It holds its last value outside DONE and must not be consumed then.
- Back-to-back operations: the second start is sampled in N+34 (IDLE) and completes in N+67.
- `busy` = (state != IDLE), registered.

## Configuration
- `JZJPCC_MULDIV_EARLY_OUT_EN`
  - **Defined**: when started from IDLE, three cases skip RUN and go directly to DONE in N+1 with the correct special result, for a total occupancy of 2 cycles (N, N+1):
    - divide by zero,
    - signed divide overflow,
    - multiply with either operand 0.
  - **Not defined**: every operation takes the full 34 cycles. Special-case values are identical either way.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD started in cycle N: stall high N to N+32, `resultValid_execute` only in N+33 with 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF. MULH 0xFFFFFFFF × 0xFFFFFFFF gives 0x00000000.
- Signed DIV and REM:
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
  - DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF.
- Divide by zero, DIVU and REMU with rs1=0x1234, rs2=0:
  - DIVU gives 0xFFFFFFFF; REMU gives 0x1234.
  - Latency is 2 cycles with `JZJPCC_MULDIV_EARLY_OUT_EN` defined and 34 without.
- Flush and restart:
  - `flush_execute` in N+10 gives IDLE in N+11, no valid strobe, stall low from N+11.
  - A new start in N+11 completes in N+44.
- Async reset asserted in N+5 mid-RUN: all outputs 0 immediately. After release, a DIVU 100/7 started in cycle M returns 14 in M+33.

Source files
------------

// File: rtl/jzjpcc_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the execute stage (shift-add / restoring).
// Optional: define JZJPCC_MULDIV_EARLY_OUT_EN to finish div-by-zero, signed overflow and x0 multiplies in one cycle.
module jzjpcc_muldiv_sequencer #(
    parameter int PC_MAX_B = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_execute,
    input  logic [2:0]  mulDivOp_execute,
    input  logic [31:0] rs1_execute,
    input  logic [31:0] rs2_execute,
    input  logic        flush_execute,
    output logic        stall_execute,
    output logic [31:0] mulDivResult_execute,
    output logic        resultValid_execute,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hold_q, hold_d;

    logic        start_ok, is_div, s1, s2, neg1, neg2, div_zero, div_ovf, mul_zero, early;
    logic [31:0] abs1, abs2, result_word;
    logic [32:0] mul_sum, div_trial;
    logic [63:0] product;

    // Operand decode for the instruction currently offered by execute
    always_comb begin
        is_div   = mulDivOp_execute[2];
        s1       = (mulDivOp_execute == 3'd1) || (mulDivOp_execute == 3'd2) ||
                   (mulDivOp_execute == 3'd4) || (mulDivOp_execute == 3'd6);
        s2       = (mulDivOp_execute == 3'd1) || (mulDivOp_execute == 3'd4) ||
                   (mulDivOp_execute == 3'd6);
        neg1     = s1 & rs1_execute[31];
        neg2     = s2 & rs2_execute[31];
        abs1     = neg1 ? -rs1_execute : rs1_execute;
        abs2     = neg2 ? -rs2_execute : rs2_execute;
        div_zero = is_div && (rs2_execute == 32'd0);
        div_ovf  = ((mulDivOp_execute == 3'd4) || (mulDivOp_execute == 3'd6)) &&
                   (rs1_execute == 32'h8000_0000) && (rs2_execute == 32'hFFFF_FFFF);
        mul_zero = !is_div && ((rs1_execute == 32'd0) || (rs2_execute == 32'd0));
`ifdef JZJPCC_MULDIV_EARLY_OUT_EN
        early    = div_zero || div_ovf || mul_zero;
`else
        early    = 1'b0;
`endif
        start_ok = (state_q == S_IDLE) && start_execute && !flush_execute;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            hold_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            neg_lo_q  <= neg_lo_d;
            neg_rem_q <= neg_rem_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = early ? S_DONE : S_RUN;
            S_RUN:  if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_execute) state_d = S_IDLE;
    end

    // Datapath next-values
    always_comb begin
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        hold_d    = hold_q;
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_trial = acc_q[63:31] - {1'b0, opb_q};
        if (start_ok) begin
            op_d      = mulDivOp_execute;
            opb_d     = is_div ? abs2 : abs1;
            acc_d     = is_div ? {32'd0, abs1} : {32'd0, abs2};
            cnt_d     = 5'd0;
            // A zero divisor yields all-ones quotient whatever the operand signs
            neg_lo_d  = (neg1 ^ neg2) & ~div_zero;
            neg_rem_d = neg1;
`ifdef JZJPCC_MULDIV_EARLY_OUT_EN
            if (div_zero)      acc_d = {abs1, 32'hFFFF_FFFF};
            else if (div_ovf)  acc_d = {32'd0, 32'h8000_0000};
            else if (mul_zero) acc_d = 64'd0;
`endif
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + 5'd1;
            if (op_q[2]) begin
                if (!div_trial[32]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                else                acc_d = {acc_q[62:0], 1'b0};
            end else begin
                acc_d = {mul_sum, acc_q[31:1]};
            end
        end else if (state_q == S_DONE) begin
            hold_d = result_word;
        end
    end

    // Output logic: sign fix-up and word select from the finished datapath
    always_comb begin
        product = neg_lo_q ? -acc_q : acc_q;
        case (op_q)
            3'd0:       result_word = product[31:0];
            3'd1, 3'd2,
            3'd3:       result_word = product[63:32];
            3'd4, 3'd5: result_word = neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
            default:    result_word = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
        endcase
        mulDivResult_execute = (state_q == S_DONE) ? result_word : hold_q;
        resultValid_execute  = (state_q == S_DONE) && !flush_execute;
        stall_execute        = !reset && (start_ok || (state_q == S_RUN));
        busy                 = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_jzjpcc_muldiv_sequencer.sv
// Directed bench for jzjpcc_muldiv_sequencer: results, latency, stall, flush and async reset.
module tb_jzjpcc_muldiv_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        start_execute;
    logic [2:0]  mulDivOp_execute;
    logic [31:0] rs1_execute;
    logic [31:0] rs2_execute;
    logic        flush_execute;
    logic        stall_execute;
    logic [31:0] mulDivResult_execute;
    logic        resultValid_execute;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

`ifdef JZJPCC_MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    jzjpcc_muldiv_sequencer #(.PC_MAX_B(31)) dut (
        .clock                (clock),
        .reset                (reset),
        .start_execute        (start_execute),
        .mulDivOp_execute     (mulDivOp_execute),
        .rs1_execute          (rs1_execute),
        .rs2_execute          (rs2_execute),
        .flush_execute        (flush_execute),
        .stall_execute        (stall_execute),
        .mulDivResult_execute (mulDivResult_execute),
        .resultValid_execute  (resultValid_execute),
        .busy                 (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called mid-cycle (just after a negedge); that cycle is N
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit stall_ok;
        start_execute    = 1'b1;
        mulDivOp_execute = op;
        rs1_execute      = a;
        rs2_execute      = b;
        lat      = 0;
        stall_ok = 1'b1;
        #1;
        while (!resultValid_execute && lat < 100) begin
            if (!stall_execute) stall_ok = 1'b0;
            @(negedge clock); #1;
            lat++;
        end
        $display("op %-10s rs1=%h rs2=%h -> %h latency %0d", tag, a, b, mulDivResult_execute, lat);
        check({tag, "_result"}, mulDivResult_execute, exp_res);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_run"}, {31'd0, stall_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'd0, stall_execute}, 32'd0);
        start_execute = 1'b0;
        @(negedge clock); #1;
        check({tag, "_idle"}, {30'd0, busy, resultValid_execute}, 32'd0);
    endtask

    initial begin
        bit saw_valid;
        reset = 1'b1; start_execute = 1'b0; flush_execute = 1'b0;
        mulDivOp_execute = 3'd0; rs1_execute = 32'd0; rs2_execute = 32'd0;
        #1;
        check("reset_outs", {29'd0, stall_execute, resultValid_execute, busy}, 32'd0);
        check("reset_result", mulDivResult_execute, 32'd0);
        @(negedge clock); reset = 1'b0; #1;

        do_op("MUL",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("MULHU",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("MULHSU",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("MULH",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("DIV_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        do_op("REM_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
        do_op("DIV_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op("REM_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        do_op("DIVU_z",     3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, SPEC_LAT);
        do_op("REMU_z",     3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, SPEC_LAT);
        do_op("DIV_z",      3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, SPEC_LAT);
        do_op("REM_z",      3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, SPEC_LAT);
        do_op("MUL_x0",     3'd0, 32'h0000_1234,  32'd0,         32'h0000_0000, SPEC_LAT);
        do_op("MULHU_0x",   3'd3, 32'd0,          32'd5,         32'h0000_0000, SPEC_LAT);
        do_op("REMU_100_7", 3'd7, 32'd100,        32'd7,         32'd2,         33);

        // Flush in N+10, fresh start in N+11
        start_execute = 1'b1; mulDivOp_execute = 3'd5; rs1_execute = 32'd1000; rs2_execute = 32'd3;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clock); #1;
            if (resultValid_execute) saw_valid = 1'b1;
        end
        flush_execute = 1'b1; #1;
        if (resultValid_execute) saw_valid = 1'b1;
        @(negedge clock);
        flush_execute = 1'b0; start_execute = 1'b0; #1;
        $display("flush at N+10: busy=%b stall=%b valid=%b", busy, stall_execute, resultValid_execute);
        check("flush_idle", {29'd0, busy, stall_execute, resultValid_execute}, 32'd0);
        check("flush_no_valid", {31'd0, saw_valid}, 32'd0);
        do_op("MUL_after_flush", 3'd0, 32'd5, 32'd6, 32'd30, 33);

        // Asynchronous reset mid-RUN
        start_execute = 1'b1; mulDivOp_execute = 3'd3; rs1_execute = 32'hDEAD_BEEF; rs2_execute = 32'h1234_5678;
        repeat (5) begin
            @(negedge clock); #1;
        end
        reset = 1'b1; start_execute = 1'b0; #1;
        $display("async reset mid-run: busy=%b stall=%b valid=%b result=%h",
                 busy, stall_execute, resultValid_execute, mulDivResult_execute);
        check("midrun_reset_outs", {29'd0, stall_execute, resultValid_execute, busy}, 32'd0);
        check("midrun_reset_result", mulDivResult_execute, 32'd0);
        @(negedge clock); reset = 1'b0; #1;
        do_op("DIVU_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
